// File: rtl/cmult_sched.sv
// cmult_sched: round-robin scheduler in front of one shared pipelined complex
// multiplier. It grants at most one requester per cycle, tags every issued
// operation with its requester id through a LAT-deep pipeline, and queues
// results in a credit-protected first-word-fall-through FIFO.
module cmult_sched #(
    parameter  int Q     = 8,
    parameter  int N     = 16,
    parameter  int NREQ  = 4,
    parameter  int LAT   = 6,
    parameter  int DEPTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_ar,
    input  logic [NREQ*N-1:0] req_ai,
    input  logic [NREQ*N-1:0] req_br,
    input  logic [NREQ*N-1:0] req_bi,
    output logic [N-1:0]      mult_ar,
    output logic [N-1:0]      mult_ai,
    output logic [N-1:0]      mult_br,
    output logic [N-1:0]      mult_bi,
    input  logic [N-1:0]      mult_pr,
    input  logic [N-1:0]      mult_pi,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [N-1:0]      res_pr,
    output logic [N-1:0]      res_pi,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH + 1);   // counts 0..DEPTH
    localparam int PW = $clog2(DEPTH);       // FIFO pointer
    localparam int EW = IDW + 2 * N;         // FIFO entry {id, pr, pi}

    // Q only describes the operand format seen by the external multiplier;
    // it is checked here so a bad configuration fails at elaboration.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("cmult_sched: Q must lie in [0, N-1]");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("cmult_sched: NREQ must lie in [2, 8]");
    end
    if (LAT < 2 || DEPTH < LAT) begin : g_bad_depth
        $error("cmult_sched: need LAT >= 2 and DEPTH >= LAT");
    end

    logic [IDW-1:0]           last_q, last_d;
    logic [LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic [CW-1:0]            fifo_count_q, fifo_count_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]            fifo_mem_q [DEPTH];

    logic                     found;
    logic                     grant;
    logic [IDW-1:0]           winner;
    logic                     issue_ok;
    logic [CW:0]              credits_used;
    logic                     push;
    logic                     pop;

    // Credits cover everything issued but not yet popped; a pop frees its
    // credit only once the registered count has dropped.
    always_comb begin
        credits_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};
        issue_ok     = credits_used < (CW + 1)'(DEPTH);
    end

    // Round-robin search starting just after the last winner; operands of the
    // winner are steered to the multiplier, zeros otherwise.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        found     = 1'b0;
        winner    = last_q;
        req_ready = '0;
        mult_ar   = '0;
        mult_ai   = '0;
        mult_br   = '0;
        mult_bi   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!found && req_valid[(int'(last_q) + off) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(last_q) + off) % NREQ);
            end
        end
        grant = found && issue_ok && !rst;
        if (grant) begin
            req_ready[winner] = 1'b1;
            mult_ar = req_ar[winner*N +: N];
            mult_ai = req_ai[winner*N +: N];
            mult_br = req_br[winner*N +: N];
            mult_bi = req_bi[winner*N +: N];
        end
    end

    // Next-state for the pointer, tag pipeline, credit counters and FIFO pointers.
    always_comb begin
        push      = tag_vld_q[LAT-1];
        pop       = res_valid && res_ready;
        last_d    = grant ? winner : last_q;
        tag_vld_d = {tag_vld_q[LAT-2:0], grant};
        tag_id_d  = {tag_id_q[LAT-2:0], winner};

        inflight_d = inflight_q;
        case ({grant, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Control state; reset discards all tags so late multiplier outputs are ignored.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (rst) begin
            last_q       <= IDW'(NREQ - 1);
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            last_q       <= last_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Result storage written when the oldest tag stage is valid.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only observable
        // behind fifo_count, so stale contents can never escape.
        if (!rst && push) begin
            fifo_mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], mult_pr, mult_pi};
        end
    end

    // Head of the FIFO falls through; outputs are forced to zero when empty.
    always_comb begin
        res_valid = fifo_count_q != '0;
        busy      = (inflight_q != '0) || res_valid;
        {res_id, res_pr, res_pi} = res_valid ? fifo_mem_q[rd_ptr_q] : '0;
    end

    // Credits bound occupancy, so a push into a full FIFO is a design error.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count_q == CW'(DEPTH)));

endmodule
